// File: rtl/ex_muldiv_if.sv
// Handshake and data bundle for the EX-stage iterative multiply/divide unit.
//   start_i, annul_i, op_i, opdata1_i, opdata2_i : request side (pipeline -> unit)
//   hi_o, lo_o, done_o, busy_o, stall_req_o, div_zero_o : result/status side
// master: pipeline driving requests; slave: the multiply/divide unit.
interface ex_muldiv_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start_i;
    logic             annul_i;
    logic [1:0]       op_i;
    logic [WIDTH-1:0] opdata1_i;
    logic [WIDTH-1:0] opdata2_i;
    logic [WIDTH-1:0] hi_o;
    logic [WIDTH-1:0] lo_o;
    logic             done_o;
    logic             busy_o;
    logic             stall_req_o;
    logic             div_zero_o;

    modport master (
        output start_i, annul_i, op_i, opdata1_i, opdata2_i,
        input  hi_o, lo_o, done_o, busy_o, stall_req_o, div_zero_o
    );

    modport slave (
        input  start_i, annul_i, op_i, opdata1_i, opdata2_i,
        output hi_o, lo_o, done_o, busy_o, stall_req_o, div_zero_o
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: MULTU/MULT/DIVU/DIV,
// one bit per cycle, HI/LO results registered and held until the next
// completed operation.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-low reset
//   bus  - ex_muldiv_if.slave: start_i/annul_i/op_i/opdata1_i/opdata2_i in,
//          hi_o/lo_o/done_o/busy_o/stall_req_o/div_zero_o out
// op_i: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
module ex_muldiv #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst,
    ex_muldiv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t               state, state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;       // MUL: product; DIV: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0]   acc_step;
    logic [2*WIDTH-1:0]   mcand;     // multiplicand, shifted left each MUL step
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     mplier;    // MUL: multiplier (shifted right); DIV: divisor magnitude
    logic                 sign1, sign2;
    logic [WIDTH-1:0]     hi_q, lo_q;
    logic                 dz_q;
    logic [WIDTH-1:0]     mag1, mag2;
    logic [WIDTH:0]       trial;
    logic [WIDTH-1:0]     res_hi, res_lo;
    logic                 accept, last, div_by_zero, op_signed;

    assign op_signed   = bus.op_i[0];
    assign accept      = (state == IDLE) && bus.start_i && !bus.annul_i;
    assign div_by_zero = bus.op_i[1] && (bus.opdata2_i == '0);
    assign last        = (cnt == CNT_W'(WIDTH - 1));
    assign mag1 = (op_signed && bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign mag2 = (op_signed && bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // One iteration of shift-add multiply or restoring divide.
    always_comb begin
        acc_step = acc;
        trial    = '0;
        if (state == MUL) begin
            if (mplier[0])
                acc_step = acc + mcand;
        end else if (state == DIV) begin
            // Shifted remainder needs WIDTH+1 bits; trial[WIDTH] is the borrow.
            trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mplier};
            if (!trial[WIDTH])
                acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            else
                acc_step = {acc[2*WIDTH-2:0], 1'b0};
        end
    end

    // Sign fixup of the final iteration's result, taken on entry to DONE.
    always_comb begin
        prod_fix = (sign1 ^ sign2) ? -acc_step : acc_step;
        if (state == MUL) begin
            res_hi = prod_fix[2*WIDTH-1:WIDTH];
            res_lo = prod_fix[WIDTH-1:0];
        end else begin
            res_hi = sign1 ? -acc_step[2*WIDTH-1:WIDTH] : acc_step[2*WIDTH-1:WIDTH];
            res_lo = (sign1 ^ sign2) ? -acc_step[WIDTH-1:0] : acc_step[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!bus.op_i[1])
                        state_nxt = MUL;
                    else if (div_by_zero)
                        state_nxt = DONE;
                    else
                        state_nxt = DIV;
                end
            end
            MUL, DIV: begin
                if (bus.annul_i)
                    state_nxt = IDLE;
                else if (last)
                    state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            sign1  <= 1'b0;
            sign2  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            dz_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt    <= '0;
                        acc    <= bus.op_i[1] ? {{WIDTH{1'b0}}, mag1} : '0;
                        mcand  <= {{WIDTH{1'b0}}, mag1};
                        mplier <= mag2;
                        sign1  <= op_signed && bus.opdata1_i[WIDTH-1];
                        sign2  <= op_signed && bus.opdata2_i[WIDTH-1];
                        if (div_by_zero) begin
                            hi_q <= '0;
                            lo_q <= '0;
                            dz_q <= 1'b1;
                        end
                    end
                end
                MUL, DIV: begin
                    if (!bus.annul_i) begin
                        acc   <= acc_step;
                        cnt   <= cnt + CNT_W'(1);
                        mcand <= mcand << 1;
                        if (state == MUL)
                            mplier <= mplier >> 1;
                        if (last) begin
                            hi_q <= res_hi;
                            lo_q <= res_lo;
                            dz_q <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;
    assign bus.div_zero_o  = dz_q;
    assign bus.done_o      = (state == DONE);
    assign bus.busy_o      = (state == MUL) || (state == DIV);
    assign bus.stall_req_o = accept || (state == MUL) || (state == DIV);
endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: scoreboard of expected HI/LO/div_zero
// pushed at issue and popped on done_o, plus latency/stall/annul/reset checks.
module tb_ex_muldiv;
    typedef struct packed {
        logic        dz;
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ex_muldiv_if #(.WIDTH(32)) bus ();
    ex_muldiv_if #(.WIDTH(8))  bus8 ();

    ex_muldiv #(.WIDTH(32), .CNT_W(6)) dut  (.clk(clk), .rst(rst), .bus(bus));
    ex_muldiv #(.WIDTH(8),  .CNT_W(4)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int   checks = 0;
    int   errors = 0;
    res_t sb_q[$];
    res_t exp_r;
    res_t last_res;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result computed with 64-bit integer arithmetic.
    function automatic res_t model(input logic [1:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input int w);
        res_t r;
        longint unsigned mask;
        longint sa, sb, p;
        mask = (64'd1 << w) - 64'd1;
        sa = longint'({32'd0, a} & mask);
        sb = longint'({32'd0, b} & mask);
        if (op[0]) begin
            sa = (sa << (64 - w)) >>> (64 - w);
            sb = (sb << (64 - w)) >>> (64 - w);
        end
        r = '0;
        if (!op[1]) begin
            p    = sa * sb;
            r.hi = 32'((p >> w) & mask);
            r.lo = 32'(p & mask);
        end else if (sb == 0) begin
            r.dz = 1'b1;
        end else begin
            p    = sa / sb;
            r.lo = 32'(p & mask);
            p    = sa % sb;
            r.hi = 32'(p & mask);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst && bus.done_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(bus.done_o), 64'd0);
            end else begin
                exp_r = sb_q.pop_front();
                check("hi", 64'(bus.hi_o), 64'(exp_r.hi));
                check("lo", 64'(bus.lo_o), 64'(exp_r.lo));
                check("div_zero", 64'(bus.div_zero_o), 64'(exp_r.dz));
                last_res = exp_r;
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int lat_exp, input bit check_stall);
        int lat;
        sb_q.push_back(model(op, a, b, 32));
        bus.op_i      = op;
        bus.opdata1_i = a;
        bus.opdata2_i = b;
        bus.start_i   = 1'b1;
        #1;
        check("stall_start", 64'(bus.stall_req_o), 64'd1);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        lat = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (bus.done_o === 1'b1) begin
                lat = i;
                break;
            end
            if (check_stall)
                check("stall_busy", 64'(bus.stall_req_o), 64'd1);
        end
        check("latency", 64'(lat), 64'(lat_exp));
        if (check_stall)
            check("stall_done", 64'(bus.stall_req_o), 64'd0);
        check("busy_done", 64'(bus.busy_o), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        res_t        e8;
        int          lat8;

        bus.start_i = 1'b0;  bus.annul_i = 1'b0;  bus.op_i = '0;
        bus.opdata1_i = '0;  bus.opdata2_i = '0;
        bus8.start_i = 1'b0; bus8.annul_i = 1'b0; bus8.op_i = '0;
        bus8.opdata1_i = '0; bus8.opdata2_i = '0;
        last_res = '0;

        repeat (2) @(negedge clk);
        check("rst_hi", 64'(bus.hi_o), 64'd0);
        check("rst_lo", 64'(bus.lo_o), 64'd0);
        check("rst_done", 64'(bus.done_o), 64'd0);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_stall", 64'(bus.stall_req_o), 64'd0);
        check("rst_dz", 64'(bus.div_zero_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 1'b1);
        do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 33, 1'b0);
        do_op(2'b00, 32'hFFFF_FFFD, 32'd7, 33, 1'b0);
        do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 33, 1'b0);
        do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 33, 1'b0);
        do_op(2'b10, 32'd100, 32'd7, 33, 1'b0);
        do_op(2'b10, 32'd100, 32'd0, 1, 1'b1);
        do_op(2'b00, 32'd2, 32'd3, 33, 1'b0);

        for (int n = 0; n < 8; n++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            do_op(rop, ra, rb, (rop[1] && rb == 32'd0) ? 1 : 33, 1'b0);
        end

        // Annul mid-multiply: no done, outputs keep the previous result.
        bus.op_i = 2'b00; bus.opdata1_i = 32'd5; bus.opdata2_i = 32'd5;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (10) @(negedge clk);
        check("busy_before_annul", 64'(bus.busy_o), 64'd1);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        bus.annul_i = 1'b0;
        check("busy_after_annul", 64'(bus.busy_o), 64'd0);
        check("stall_after_annul", 64'(bus.stall_req_o), 64'd0);
        repeat (40) @(negedge clk);
        check("annul_hold_hi", 64'(bus.hi_o), 64'(last_res.hi));
        check("annul_hold_lo", 64'(bus.lo_o), 64'(last_res.lo));
        check("annul_hold_dz", 64'(bus.div_zero_o), 64'(last_res.dz));

        // Start and annul together in IDLE: nothing starts.
        bus.start_i = 1'b1; bus.annul_i = 1'b1;
        #1;
        check("stall_start_annul", 64'(bus.stall_req_o), 64'd0);
        @(posedge clk);
        #1;
        bus.start_i = 1'b0; bus.annul_i = 1'b0;
        check("busy_start_annul", 64'(bus.busy_o), 64'd0);
        repeat (40) @(negedge clk);

        // Asynchronous reset in the middle of a divide.
        bus.op_i = 2'b10; bus.opdata1_i = 32'd1000; bus.opdata2_i = 32'd3;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
        repeat (5) @(negedge clk);
        check("busy_mid_div", 64'(bus.busy_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        check("arst_hi", 64'(bus.hi_o), 64'd0);
        check("arst_lo", 64'(bus.lo_o), 64'd0);
        check("arst_done", 64'(bus.done_o), 64'd0);
        check("arst_busy", 64'(bus.busy_o), 64'd0);
        check("arst_stall", 64'(bus.stall_req_o), 64'd0);
        check("arst_dz", 64'(bus.div_zero_o), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (40) @(negedge clk);

        // WIDTH=8: DIV -128 / -1.
        e8 = model(2'b11, 32'h80, 32'hFF, 8);
        bus8.op_i = 2'b11; bus8.opdata1_i = 8'h80; bus8.opdata2_i = 8'hFF;
        bus8.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus8.start_i = 1'b0;
        lat8 = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus8.done_o === 1'b1) begin
                lat8 = i;
                break;
            end
        end
        check("w8_latency", 64'(lat8), 64'd9);
        check("w8_lo", 64'(bus8.lo_o), 64'(e8.lo));
        check("w8_hi", 64'(bus8.hi_o), 64'(e8.hi));
        check("w8_dz", 64'(bus8.div_zero_o), 64'(e8.dz));

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
